// File: rtl/valu_pkg.sv
// Shared constants and types for the vector-ALU arbiter slice.
package valu_pkg;

  localparam int unsigned LANES       = 16;
  localparam int unsigned LANE_W      = 16;
  localparam int unsigned VALU_DATA_W = LANES * LANE_W;
  localparam int unsigned VALU_FLAG_W = 4 * LANES;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SUM = 3'b011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Non-vector ALU controls latched alongside the operands.
  typedef struct packed {
    logic [LANE_W-1:0] c;
    logic [2:0]        opcode;
    logic              scalar;
  } alu_ctrl_t;

endpackage

// File: rtl/valu_arbiter_if.sv
// Requester, ALU and response bundle between the arbiter and its neighbours.
interface valu_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned FLAG_W  = 64,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*16-1:0]     req_c;
  logic [NUM_REQ*3-1:0]      req_opcode;
  logic [NUM_REQ-1:0]        req_scalar;

  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [15:0]               alu_c;
  logic [2:0]                alu_opcode;
  logic                      alu_flag_scalar;
  logic [DATA_W-1:0]         alu_result;
  logic [FLAG_W-1:0]         alu_flags;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic [FLAG_W-1:0]         rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_c, req_opcode, req_scalar,
    output alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_c, alu_opcode, alu_flag_scalar,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_opcode, req_scalar,
    input  alu_result, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_c, alu_opcode, alu_flag_scalar,
    output rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/valu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the slot after the last grant.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (en_i && !found && req_i[cand[IDX_W-1:0]]) begin
        grant_o[cand[IDX_W-1:0]] = 1'b1;
        idx_o                    = cand[IDX_W-1:0];
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/valu_arbiter.sv
// Round-robin sharing of one vector ALU: issue registers, one-cycle execute, held response.
module valu_arbiter
  import valu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = VALU_DATA_W,
  parameter int unsigned FLAG_W  = VALU_FLAG_W,
  parameter int unsigned ID_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  valu_arbiter_if.slave bus,
  output logic          busy,
  output logic [31:0]   op_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  last_q;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gidx;
  logic              hs, grant_en, grant_any, count_inc;

  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  alu_ctrl_t         ctrl_q, ctrl_d;
  logic [ID_W-1:0]   pend_id_q;

  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic              busy_q;
  logic [31:0]       op_count_q;

  // Grants only from IDLE or on the response handshake; reset masks ready at once.
  assign hs        = (state_q == ST_RESP) && rsp_valid_q && bus.rsp_ready;
  assign grant_en  = !rst && ((state_q == ST_IDLE) || hs);
  assign grant_any = |gnt;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .en_i    (grant_en),
    .grant_o (gnt),
    .idx_o   (gidx)
  );

  always_comb begin
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    ctrl_d  = ctrl_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        alu_a_d       = bus.req_a[i*DATA_W +: DATA_W];
        alu_b_d       = bus.req_b[i*DATA_W +: DATA_W];
        ctrl_d.c      = bus.req_c[i*LANE_W +: LANE_W];
        ctrl_d.opcode = bus.req_opcode[i*3 +: 3];
        ctrl_d.scalar = bus.req_scalar[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_inc = 1'b0;
    case (state_q)
      ST_IDLE: if (grant_any) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (hs) begin
          count_inc = 1'b1;
          state_d   = grant_any ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= IDX_W'(NUM_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      ctrl_q       <= '0;
      pend_id_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != ST_IDLE);
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      ctrl_q     <= ctrl_d;
      op_count_q <= op_count_q + 32'(count_inc);
      if (grant_any) begin
        pend_id_q <= ID_W'(gidx);
        last_q    <= gidx;
      end
      // Capture the combinational ALU output at the end of the execute cycle.
      if (state_q == ST_EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= pend_id_q;
        rsp_result_q <= bus.alu_result;
        rsp_flags_q  <= bus.alu_flags;
      end else if (hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready       = gnt;
  assign bus.alu_a           = alu_a_q;
  assign bus.alu_b           = alu_b_q;
  assign bus.alu_c           = ctrl_q.c;
  assign bus.alu_opcode      = ctrl_q.opcode;
  assign bus.alu_flag_scalar = ctrl_q.scalar;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_result      = rsp_result_q;
  assign bus.rsp_flags       = rsp_flags_q;
  assign busy                = busy_q;
  assign op_count            = op_count_q;

endmodule

// File: tb/tb_valu_arbiter.sv
// Directed bench for valu_arbiter with a small lane-wise ALU model on the ALU side.
module tb_valu_arbiter;
  import valu_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 256;
  localparam int unsigned FW = 64;
  localparam int unsigned IW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] op_count;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  valu_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .FLAG_W(FW), .ID_W(IW)) bus ();

  valu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .FLAG_W(FW), .ID_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  // ALU stand-in: add, sub, lane-sum reduction into lane 0, xor otherwise.
  logic [DW-1:0] alu_res;
  logic [15:0]   lane_sum;
  always_comb begin
    alu_res  = '0;
    lane_sum = '0;
    for (int l = 0; l < 16; l++) begin
      lane_sum = lane_sum + bus.alu_a[l*16 +: 16];
      case (bus.alu_opcode)
        OP_ADD:  alu_res[l*16 +: 16] = bus.alu_a[l*16 +: 16] + bus.alu_b[l*16 +: 16];
        OP_SUB:  alu_res[l*16 +: 16] = bus.alu_a[l*16 +: 16] - bus.alu_b[l*16 +: 16];
        default: alu_res[l*16 +: 16] = bus.alu_a[l*16 +: 16] ^ bus.alu_b[l*16 +: 16];
      endcase
    end
    if (bus.alu_opcode == OP_SUM) alu_res = DW'(lane_sum);
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_flags  = alu_res[FW-1:0];

  logic [1:0] exp_rdy [10] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  logic       exp_rv  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] exp_id  [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
  logic [DW-1:0] res6, res4, res3, res_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a_lane, input logic [15:0] b_lane,
                         input logic [15:0] c, input logic [2:0] op, input logic sc);
    bus.req_a[i*DW +: DW]  = {16{a_lane}};
    bus.req_b[i*DW +: DW]  = {16{b_lane}};
    bus.req_c[i*16 +: 16]  = c;
    bus.req_opcode[i*3 +: 3] = op;
    bus.req_scalar[i]      = sc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    res6    = {16{16'h0006}};
    res4    = {16{16'h0004}};
    res3    = {16{16'h0003}};
    res_sum = DW'(16'h0010);

    rst            = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_c      = '0;
    bus.req_opcode = '0;
    bus.req_scalar = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) tick();
    mid();
    chk("rst_req_ready", DW'(bus.req_ready), '0);
    chk("rst_rsp_valid", DW'(bus.rsp_valid), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_op_count", DW'(op_count), '0);
    chk("rst_alu_a", bus.alu_a, '0);

    // Single request from requester 0
    tick();
    rst = 1'b0;
    set_req(0, 16'h0001, 16'h0002, 16'h1234, OP_ADD, 1'b1);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    mid();
    chk("t1_c0_req_ready", DW'(bus.req_ready), DW'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t1_c1_alu_a", bus.alu_a, {16{16'h0001}});
    chk("t1_c1_alu_b", bus.alu_b, {16{16'h0002}});
    chk("t1_c1_alu_c", DW'(bus.alu_c), DW'(16'h1234));
    chk("t1_c1_alu_op", DW'(bus.alu_opcode), DW'(OP_ADD));
    chk("t1_c1_alu_sc", DW'(bus.alu_flag_scalar), DW'(1'b1));
    chk("t1_c1_busy", DW'(busy), DW'(1'b1));
    chk("t1_c1_rsp_valid", DW'(bus.rsp_valid), '0);
    tick();
    mid();
    chk("t1_c2_rsp_valid", DW'(bus.rsp_valid), DW'(1'b1));
    chk("t1_c2_rsp_id", DW'(bus.rsp_id), '0);
    chk("t1_c2_rsp_result", bus.rsp_result, res3);
    chk("t1_c2_rsp_flags", DW'(bus.rsp_flags), DW'(64'h0003_0003_0003_0003));
    chk("t1_c2_op_count", DW'(op_count), '0);
    tick();
    mid();
    chk("t1_c3_rsp_valid", DW'(bus.rsp_valid), '0);
    chk("t1_c3_op_count", DW'(op_count), DW'(32'd1));
    chk("t1_c3_busy", DW'(busy), '0);

    // Two requesters contending, consumer always ready
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 16'h0005, 16'h0001, 16'h0000, OP_ADD, 1'b0);
    set_req(1, 16'h0007, 16'h0003, 16'h0bad, OP_SUB, 1'b0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) tick();
      mid();
      chk($sformatf("t2_c%0d_req_ready", c), DW'(bus.req_ready), DW'(exp_rdy[c]));
      chk($sformatf("t2_c%0d_rsp_valid", c), DW'(bus.rsp_valid), DW'(exp_rv[c]));
      if (exp_rv[c]) begin
        chk($sformatf("t2_c%0d_rsp_id", c), DW'(bus.rsp_id), DW'(exp_id[c]));
        chk($sformatf("t2_c%0d_rsp_result", c), bus.rsp_result, (exp_id[c] == 2'd0) ? res6 : res4);
      end
    end
    chk("t2_op_count", DW'(op_count), DW'(32'd4));
    chk("t2_busy", DW'(busy), DW'(1'b1));

    // Consumer stalls for five cycles with a response held
    tick();
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) tick();
      mid();
      chk($sformatf("t3_s%0d_req_ready", c), DW'(bus.req_ready), '0);
      chk($sformatf("t3_s%0d_rsp_valid", c), DW'(bus.rsp_valid), DW'(1'b1));
      chk($sformatf("t3_s%0d_rsp_id", c), DW'(bus.rsp_id), '0);
      chk($sformatf("t3_s%0d_rsp_result", c), bus.rsp_result, res6);
    end
    chk("t3_stall_op_count", DW'(op_count), DW'(32'd4));
    tick();
    bus.rsp_ready = 1'b1;
    mid();
    chk("t3_release_req_ready", DW'(bus.req_ready), DW'(2'b10));
    tick();
    mid();
    chk("t3_exec_rsp_valid", DW'(bus.rsp_valid), '0);
    chk("t3_exec_busy", DW'(busy), DW'(1'b1));
    chk("t3_exec_op_count", DW'(op_count), DW'(32'd5));
    chk("t3_exec_alu_op", DW'(bus.alu_opcode), DW'(OP_SUB));
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t3_rsp_valid", DW'(bus.rsp_valid), DW'(1'b1));
    chk("t3_rsp_id", DW'(bus.rsp_id), DW'(2'd1));
    chk("t3_rsp_result", bus.rsp_result, res4);
    tick();
    mid();
    chk("t3_idle_rsp_valid", DW'(bus.rsp_valid), '0);
    chk("t3_idle_busy", DW'(busy), '0);
    chk("t3_idle_op_count", DW'(op_count), DW'(32'd6));

    // Lane-sum reduction from requester 1
    tick();
    set_req(1, 16'h0001, 16'h0000, 16'h0000, OP_SUM, 1'b0);
    bus.req_valid = 2'b10;
    mid();
    chk("t4_req_ready", DW'(bus.req_ready), DW'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t4_alu_op", DW'(bus.alu_opcode), DW'(OP_SUM));
    tick();
    mid();
    chk("t4_rsp_valid", DW'(bus.rsp_valid), DW'(1'b1));
    chk("t4_rsp_id", DW'(bus.rsp_id), DW'(2'd1));
    chk("t4_rsp_result", bus.rsp_result, res_sum);
    chk("t4_rsp_flags", DW'(bus.rsp_flags), DW'(64'h10));
    tick();
    mid();
    chk("t4_op_count", DW'(op_count), DW'(32'd7));

    // Asynchronous reset in the middle of EXEC
    tick();
    bus.req_valid = 2'b11;
    mid();
    chk("t5_req_ready", DW'(bus.req_ready), DW'(2'b01));
    tick();
    mid();
    chk("t5_exec_busy", DW'(busy), DW'(1'b1));
    chk("t5_pre_op_count", DW'(op_count), DW'(32'd7));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_arst_rsp_valid", DW'(bus.rsp_valid), '0);
    chk("t5_arst_busy", DW'(busy), '0);
    chk("t5_arst_req_ready", DW'(bus.req_ready), '0);
    chk("t5_arst_op_count", DW'(op_count), '0);
    tick();
    tick();
    rst = 1'b0;
    mid();
    chk("t5_post_req_ready", DW'(bus.req_ready), DW'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    tick();
    mid();
    chk("t5_rsp_valid", DW'(bus.rsp_valid), DW'(1'b1));
    chk("t5_rsp_id", DW'(bus.rsp_id), '0);
    chk("t5_rsp_result", bus.rsp_result, res6);
    tick();
    mid();
    chk("t5_op_count", DW'(op_count), DW'(32'd1));

    // Completion counter wrap
    force dut.op_count_q = 32'hFFFF_FFFF;
    tick();
    bus.req_valid = 2'b01;
    mid();
    chk("t6_forced_op_count", DW'(op_count), DW'(32'hFFFF_FFFF));
    tick();
    bus.req_valid = 2'b00;
    tick();
    release dut.op_count_q;
    mid();
    chk("t6_rsp_valid", DW'(bus.rsp_valid), DW'(1'b1));
    chk("t6_pre_wrap_op_count", DW'(op_count), DW'(32'hFFFF_FFFF));
    tick();
    mid();
    chk("t6_wrap_op_count", DW'(op_count), '0);
    chk("t6_idle_rsp_valid", DW'(bus.rsp_valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
